// File: rtl/cache_control_pkg.sv
// cache_ctrl_pkg: shared states, sizes and helpers for the cache controller
package cache_ctrl_pkg;
  localparam int S_INDEX = 3;
  localparam int NUM_SETS = 2 ** S_INDEX;
  localparam int NUM_WAYS = 2;
  localparam int S_MASK = 32;
  localparam logic [S_MASK-1:0] BE_ALL = '1;
  typedef enum logic [2:0] {IDLE, CHECK, WB, FILL, FL_CHECK, FL_WB, FL_DONE} cache_state_t;
  function automatic logic [NUM_WAYS-1:0] way_mask(input logic w);
    return w ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/cache_control_if.sv
// cache_control_if: CPU, physical-memory and datapath signals of the cache controller
interface cache_control_if;
  import cache_ctrl_pkg::*;
  logic mem_read, mem_write, mem_resp;
  logic [S_MASK-1:0] mem_byte_enable256;
  logic pmem_read, pmem_write, pmem_resp, pmem_addr_sel;
  logic flush_req, flush_done;
  logic [NUM_WAYS-1:0] cmp, valid, dirty;
  logic lru;
  logic read, sel, data_in_sel, index_sel;
  logic [S_MASK-1:0] write_en0, write_en1;
  logic load_lru, load_dirty, load_valid, lru_in;
  logic [NUM_WAYS-1:0] load_tag, dirty_in, valid_in;
  logic [S_INDEX-1:0] flush_index;
  modport master (
    input mem_read, mem_write, mem_byte_enable256, pmem_resp, flush_req, cmp, valid, dirty, lru,
    output mem_resp, pmem_read, pmem_write, pmem_addr_sel, flush_done, read, write_en0, write_en1,
      sel, data_in_sel, index_sel, load_lru, load_dirty, load_valid, load_tag, lru_in, dirty_in,
      valid_in, flush_index
  );
  modport slave (
    output mem_read, mem_write, mem_byte_enable256, pmem_resp, flush_req, cmp, valid, dirty, lru,
    input mem_resp, pmem_read, pmem_write, pmem_addr_sel, flush_done, read, write_en0, write_en1,
      sel, data_in_sel, index_sel, load_lru, load_dirty, load_valid, load_tag, lru_in, dirty_in,
      valid_in, flush_index
  );
endinterface

// File: rtl/cache_control_flush_counter.sv
// cache_flush_counter: {set, way} walk pointer used while flushing dirty lines
module cache_flush_counter
  import cache_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               advance_i,
  input  logic               clear_i,
  output logic [S_INDEX-1:0] flush_index_o,
  output logic               fway_o,
  output logic               last_o
);
  logic [S_INDEX:0] ptr_q, ptr_d;
  assign ptr_d = clear_i ? '0 : advance_i ? ptr_q + (S_INDEX + 1)'(1) : ptr_q;
  assign flush_index_o = ptr_q[S_INDEX:1];
  assign fway_o = ptr_q[0];
  assign last_o = (flush_index_o == S_INDEX'(NUM_SETS - 1)) && fway_o;
  always_ff @(posedge clk or negedge rst)
    if (!rst) ptr_q <= '0;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/cache_control.sv
// cache_control: hit / write-back / fill / flush sequencer for the 2-way write-back cache
module cache_control
  import cache_ctrl_pkg::*;
(
  input logic           clk,
  input logic           rst,
  cache_control_if.master bus
);
  cache_state_t state_q, state_d;
  logic victim_q, victim_d;
  logic hit, hw, fway, last, adv, clr;
  logic [S_INDEX-1:0] fidx;
  cache_flush_counter u_cnt (
    .clk(clk), .rst(rst), .advance_i(adv), .clear_i(clr),
    .flush_index_o(fidx), .fway_o(fway), .last_o(last)
  );
  assign hit = |(bus.valid & bus.cmp);
  assign hw = bus.valid[1] & bus.cmp[1];
  assign bus.flush_index = fidx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      victim_q <= 1'b0;
    end else begin
      state_q <= state_d;
      victim_q <= victim_d;
    end
  always_comb begin
    state_d = state_q;
    victim_d = victim_q;
    adv = 1'b0;
    clr = 1'b0;
    bus.mem_resp = 1'b0;
    bus.pmem_read = 1'b0;
    bus.pmem_write = 1'b0;
    bus.pmem_addr_sel = 1'b0;
    bus.flush_done = 1'b0;
    bus.read = 1'b0;
    bus.write_en0 = '0;
    bus.write_en1 = '0;
    bus.sel = 1'b0;
    bus.data_in_sel = 1'b0;
    bus.index_sel = 1'b0;
    bus.load_lru = 1'b0;
    bus.load_dirty = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_tag = '0;
    bus.lru_in = 1'b0;
    bus.dirty_in = '0;
    bus.valid_in = '0;
    unique case (state_q)
      IDLE: state_d = (bus.mem_read | bus.mem_write) ? CHECK : bus.flush_req ? FL_CHECK : IDLE;
      CHECK: begin
        bus.read = 1'b1;
        if (hit) begin
          bus.mem_resp = 1'b1;
          bus.sel = hw;
          bus.load_lru = 1'b1;
          bus.lru_in = ~hw;
          if (bus.mem_write) begin
            bus.write_en0 = hw ? '0 : bus.mem_byte_enable256;
            bus.write_en1 = hw ? bus.mem_byte_enable256 : '0;
            bus.load_dirty = 1'b1;
            bus.dirty_in = bus.dirty | way_mask(hw);
          end
          state_d = IDLE;
        end else begin
          victim_d = bus.lru;
          state_d = (bus.valid[bus.lru] & bus.dirty[bus.lru]) ? WB : FILL;
        end
      end
      WB: begin
        bus.sel = victim_q;
        bus.pmem_addr_sel = 1'b1;
        bus.pmem_write = 1'b1;
        if (bus.pmem_resp) begin
          bus.load_dirty = 1'b1;
          bus.dirty_in = bus.dirty & ~way_mask(victim_q);
          state_d = FILL;
        end
      end
      FILL: begin
        bus.pmem_read = 1'b1;
        if (bus.pmem_resp) begin
          bus.write_en0 = victim_q ? '0 : BE_ALL;
          bus.write_en1 = victim_q ? BE_ALL : '0;
          bus.data_in_sel = 1'b1;
          bus.load_tag = way_mask(victim_q);
          bus.load_valid = 1'b1;
          bus.valid_in = bus.valid | way_mask(victim_q);
          bus.load_dirty = 1'b1;
          bus.dirty_in = bus.dirty & ~way_mask(victim_q);
          state_d = CHECK;
        end
      end
      FL_CHECK: begin
        bus.index_sel = 1'b1;
        bus.read = 1'b1;
        if (bus.valid[fway] & bus.dirty[fway]) state_d = FL_WB;
        else begin
          adv = 1'b1;
          state_d = last ? FL_DONE : FL_CHECK;
        end
      end
      FL_WB: begin
        bus.index_sel = 1'b1;
        bus.sel = fway;
        bus.pmem_addr_sel = 1'b1;
        bus.pmem_write = 1'b1;
        if (bus.pmem_resp) begin
          bus.load_dirty = 1'b1;
          bus.dirty_in = bus.dirty & ~way_mask(fway);
          adv = 1'b1;
          state_d = last ? FL_DONE : FL_CHECK;
        end
      end
      FL_DONE: begin
        bus.flush_done = 1'b1;
        clr = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_cache_control.sv
// tb_cache_control: directed checks of hit, miss, write-back, flush and reset sequencing
module tb_cache_control;
  logic clk, rst;
  logic [1:0] cpu_valid, cpu_dirty;
  logic [15:0] fd, preset;
  logic do_preset;
  int total, bad, viol;
  int wb_idx[4];
  int wbs, nd, badsel;
  logic [85:0] all_outs;
  cache_control_if bus();
  cache_control dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.dirty = bus.index_sel ? fd[{bus.flush_index, 1'b0} +: 2] : cpu_dirty;
  assign bus.valid = bus.index_sel ? 2'b11 : cpu_valid;
  assign all_outs = {bus.mem_resp, bus.pmem_read, bus.pmem_write, bus.pmem_addr_sel, bus.flush_done,
    bus.read, bus.write_en0, bus.write_en1, bus.sel, bus.data_in_sel, bus.index_sel, bus.load_lru,
    bus.load_dirty, bus.load_valid, bus.load_tag, bus.lru_in, bus.dirty_in, bus.valid_in, bus.flush_index};
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk)
    if (do_preset) fd <= preset;
    else if (bus.load_dirty && bus.index_sel) fd[{bus.flush_index, 1'b0} +: 2] <= bus.dirty_in;
  initial viol = 0;
  always @(negedge clk)
    if ((bus.pmem_read && bus.pmem_write) || (|bus.write_en0 && |bus.write_en1) || (bus.mem_resp && !bus.read))
      viol++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic run_flush();
    bit done = 1'b0;
    wbs = 0;
    nd = 0;
    badsel = 0;
    for (int c = 0; c < 60 && !done; c++) begin
      if ((bus.read | bus.pmem_write) && !bus.index_sel) badsel++;
      if (bus.pmem_write) begin
        if (wbs < 4) wb_idx[wbs] = int'(bus.flush_index);
        wbs++;
      end
      bus.pmem_resp = bus.pmem_write;
      if (bus.flush_done) begin
        nd++;
        bus.flush_req = 1'b0;
        done = 1'b1;
      end
      tick();
    end
    bus.pmem_resp = 1'b0;
    chk("flush_timeout", 32'(done), 1);
  endtask
  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    do_preset = 1'b0;
    preset = '0;
    cpu_valid = '0;
    cpu_dirty = '0;
    bus.mem_read = 1'b0;
    bus.mem_write = 1'b0;
    bus.mem_byte_enable256 = '0;
    bus.pmem_resp = 1'b0;
    bus.flush_req = 1'b0;
    bus.cmp = '0;
    bus.lru = 1'b0;
    #1;
    chk("reset_outs", 32'(|all_outs), 0);
    do_preset = 1'b1;
    repeat (2) tick();
    do_preset = 1'b0;
    rst = 1'b1;
    // clean read miss into way 0
    bus.mem_read = 1'b1;
    tick();
    chk("rm_check_read", 32'(bus.read), 1);
    chk("rm_check_noresp", 32'(bus.mem_resp), 0);
    tick();
    chk("rm_fill_pread", 32'(bus.pmem_read), 1);
    chk("rm_fill_asel", 32'(bus.pmem_addr_sel), 0);
    chk("rm_fill_nowe", bus.write_en0, 0);
    bus.pmem_resp = 1'b1;
    #1;
    chk("rm_fill_we0", bus.write_en0, 32'hFFFF_FFFF);
    chk("rm_fill_we1", bus.write_en1, 0);
    chk("rm_fill_tag", 32'(bus.load_tag), 1);
    chk("rm_fill_valid", 32'(bus.valid_in), 1);
    chk("rm_fill_dsel", 32'(bus.data_in_sel), 1);
    tick();
    bus.pmem_resp = 1'b0;
    cpu_valid = 2'b01;
    bus.cmp = 2'b01;
    bus.lru = 1'b1;
    #1;
    chk("rm_hit_resp", 32'(bus.mem_resp), 1);
    chk("rm_hit_sel", 32'(bus.sel), 0);
    chk("rm_hit_lru", 32'(bus.lru_in), 1);
    tick();
    bus.mem_read = 1'b0;
    chk("rm_idle_noresp", 32'(bus.mem_resp), 0);
    // write hit way 1
    cpu_valid = 2'b11;
    bus.cmp = 2'b10;
    bus.mem_write = 1'b1;
    bus.mem_byte_enable256 = 32'h0000_000F;
    tick();
    chk("wh_we1", bus.write_en1, 32'h0000_000F);
    chk("wh_we0", bus.write_en0, 0);
    chk("wh_dirty_in", 32'(bus.dirty_in), 2);
    chk("wh_load_dirty", 32'(bus.load_dirty), 1);
    chk("wh_lru", 32'(bus.lru_in), 0);
    chk("wh_resp", 32'(bus.mem_resp), 1);
    tick();
    bus.mem_write = 1'b0;
    chk("wh_idle", 32'(bus.mem_resp), 0);
    // dirty miss, victim way 1
    bus.cmp = 2'b00;
    cpu_dirty = 2'b10;
    bus.lru = 1'b1;
    bus.mem_read = 1'b1;
    tick();
    chk("dm_check_nopw", 32'(bus.pmem_write), 0);
    tick();
    chk("dm_wb_pw", 32'(bus.pmem_write), 1);
    chk("dm_wb_asel", 32'(bus.pmem_addr_sel), 1);
    chk("dm_wb_sel", 32'(bus.sel), 1);
    chk("dm_wb_nopr", 32'(bus.pmem_read), 0);
    tick();
    chk("dm_wb_hold", 32'(bus.pmem_write), 1);
    bus.pmem_resp = 1'b1;
    #1;
    chk("dm_wb_ld", 32'(bus.load_dirty), 1);
    chk("dm_wb_din", 32'(bus.dirty_in), 0);
    tick();
    bus.pmem_resp = 1'b0;
    cpu_dirty = 2'b00;
    #1;
    chk("dm_fill_pr", 32'(bus.pmem_read), 1);
    chk("dm_fill_nopw", 32'(bus.pmem_write), 0);
    bus.pmem_resp = 1'b1;
    #1;
    chk("dm_fill_we1", bus.write_en1, 32'hFFFF_FFFF);
    chk("dm_fill_tag", 32'(bus.load_tag), 2);
    chk("dm_fill_valid", 32'(bus.valid_in), 3);
    tick();
    bus.pmem_resp = 1'b0;
    bus.cmp = 2'b10;
    #1;
    chk("dm_hit_resp", 32'(bus.mem_resp), 1);
    chk("dm_hit_sel", 32'(bus.sel), 1);
    chk("dm_hit_lru", 32'(bus.lru_in), 0);
    tick();
    bus.mem_read = 1'b0;
    // flush with set 2 way 0 and set 7 way 1 dirty
    preset = 16'h8010;
    do_preset = 1'b1;
    tick();
    do_preset = 1'b0;
    bus.flush_req = 1'b1;
    #1;
    run_flush();
    chk("fl_wbs", 32'(wbs), 2);
    chk("fl_idx0", 32'(wb_idx[0]), 2);
    chk("fl_idx1", 32'(wb_idx[1]), 7);
    chk("fl_done_cnt", 32'(nd), 1);
    chk("fl_index_sel", 32'(badsel), 0);
    chk("fl_ptr_zero", 32'(bus.flush_index), 0);
    chk("fl_cleaned", 32'(fd), 0);
    tick();
    chk("fl_no_restart", 32'(bus.read | bus.flush_done), 0);
    // simultaneous CPU request and flush request
    preset = 16'h0040;
    do_preset = 1'b1;
    tick();
    do_preset = 1'b0;
    cpu_valid = 2'b01;
    bus.cmp = 2'b01;
    bus.mem_read = 1'b1;
    bus.flush_req = 1'b1;
    tick();
    chk("pr_cpu_first", 32'(bus.mem_resp), 1);
    chk("pr_cpu_isel", 32'(bus.index_sel), 0);
    tick();
    bus.mem_read = 1'b0;
    run_flush();
    chk("pr_wbs", 32'(wbs), 1);
    chk("pr_idx0", 32'(wb_idx[0]), 3);
    chk("pr_done_cnt", 32'(nd), 1);
    // reset in the middle of a fill
    cpu_valid = 2'b00;
    bus.cmp = 2'b00;
    bus.lru = 1'b0;
    bus.mem_read = 1'b1;
    tick();
    tick();
    chk("rs_fill_pr", 32'(bus.pmem_read), 1);
    rst = 1'b0;
    #1;
    chk("rs_outs_zero", 32'(|all_outs), 0);
    bus.mem_read = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rs_idle", 32'(|all_outs), 0);
    cpu_valid = 2'b01;
    bus.cmp = 2'b01;
    bus.mem_read = 1'b1;
    tick();
    chk("rs_restart_resp", 32'(bus.mem_resp), 1);
    chk("rs_restart_sel", 32'(bus.sel), 0);
    tick();
    bus.mem_read = 1'b0;
    chk("invariants", 32'(viol), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
